game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 50: cycles the target pattern is displayed (legal 1..65535).
REQ-002 SHALL have parameter INPUT_CYCLES, default 200: cycles allowed for player entry (legal 1..65535).
REQ-003 SHALL have parameter MAX_ROUNDS, default 9: correct rounds needed to win (legal 1..15).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1: pattern generator reset value (nonzero).
REQ-005 SHALL use one clock, clk, with reset rst synchronous and active-high.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- enable  in  1  start/continue game; low aborts
- bIn  in  1  submit button, level-sensitive, rising edge detected internally
- switchIn  in  16  player guess
- redLight  out  16  pattern display
- score  out  4  correct rounds, saturating
- round  out  4  current round index
- gameWait  out  1  high while pattern is shown
- timerEnable  out  1  high while the entry timer runs
- gameTimeout  out  1  one-cycle pulse on entry-timer expiry
- endGame  out  1  high in DONE
- win  out  1  high in DONE after MAX_ROUNDS correct rounds

Function
REQ-007 All outputs SHALL be registered.
REQ-008 FSM states SHALL be IDLE, GEN, SHOW, WAIT_IN, CHECK, DONE.
REQ-009 IDLE: enable=1 -> GEN; on this transition score, round and win SHALL clear to 0.
REQ-010 GEN, 1 cycle: advance the LFSR once and latch the new value as pattern; then -> SHOW.
REQ-011 LFSR step SHALL be Galois: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 16'h0000); from seed 16'hACE1 the first two patterns are 16'hE270 and 16'h7138.
REQ-012 SHOW SHALL last exactly SHOW_CYCLES cycles with redLight=pattern and gameWait=1; then -> WAIT_IN.
REQ-013 WAIT_IN: redLight=0, timerEnable=1; a 16-bit down-counter loads INPUT_CYCLES-1 on entry and decrements each cycle.
REQ-014 A bIn rising edge (bIn=1, previous-cycle bIn=0) in WAIT_IN SHALL -> CHECK; bIn held high on entry SHALL NOT count as an edge; edges in any other state SHALL be ignored.
REQ-015 Counter at 0 with no edge that cycle SHALL -> DONE, win=0, and gameTimeout=1 for exactly the first DONE cycle.
REQ-016 Edge and expiry in the same cycle: the submission SHALL win (-> CHECK, no gameTimeout).
REQ-017 CHECK, 1 cycle: compare the switchIn sampled that cycle against pattern.
REQ-018 On a match, score SHALL increment (saturating at 15) and round SHALL increment; if the new round equals MAX_ROUNDS -> DONE with win=1, else -> GEN.
REQ-019 On a mismatch -> DONE with win=0; score and round SHALL be unchanged.
REQ-020 DONE: endGame=1, redLight=0, score/round/win held; enable=0 -> IDLE.
REQ-021 enable=0 in GEN, SHOW, WAIT_IN or CHECK SHALL -> IDLE next cycle, with all status outputs cleared and score and round held until the next start.
REQ-022 The LFSR SHALL NOT reset between games; successive games continue the sequence.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, lfsr=LFSR_SEED, pattern=0, counters=0, previous-bIn=0, and every output to 0, overriding any state including mid-game.

Verification (SHOW_CYCLES=4, INPUT_CYCLES=10, MAX_ROUNDS=2)
REQ-024 Win path: rst, enable=1, enter switchIn=16'hE270 and pulse bIn in round 0, then 16'h7138 in round 1 -> redLight=16'hE270 for 4 cycles, then 16'h7138 for 4 cycles; finally score=2, win=1, endGame=1.
REQ-025 Mismatch: round 0 with switchIn=16'h0000 and bIn pulsed -> DONE, score=0, win=0, gameTimeout never asserted.
REQ-026 Timeout: no bIn in WAIT_IN -> timerEnable high exactly 10 cycles, then gameTimeout high 1 cycle, endGame=1.
REQ-027 Edge rules: bIn held high from SHOW into WAIT_IN -> no CHECK; bIn edge on the expiry cycle -> CHECK taken, no gameTimeout.
REQ-028 Abort/reset: enable=0 mid-SHOW -> IDLE next cycle with redLight=0; rst mid-WAIT_IN -> all outputs 0 and the next pattern is 16'hE270.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer
// Memory-style "copy the lights" game controller.
// Each round shows a pseudo-random 16-bit pattern, then waits for the player
// to submit a matching guess on the switches.
// The player wins after MAX_ROUNDS correct rounds.
// The game ends at once on a wrong guess or on an entry timeout.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       start/continue the game; low aborts back to idle
//   bIn          submit button (level), rising edge detected internally
//   switchIn     player guess
//   redLight     pattern display (only non-zero while showing)
//   score        correct rounds, saturating at 15
//   round        current round index
//   gameWait     high while the pattern is shown
//   timerEnable  high while the entry timer runs
//   gameTimeout  one-cycle pulse on the first DONE cycle after an entry timeout
//   endGame      high in DONE
//   win          high in DONE after MAX_ROUNDS correct rounds
module game_sequencer #(
    parameter int unsigned SHOW_CYCLES  = 50,
    parameter int unsigned INPUT_CYCLES = 200,
    parameter int unsigned MAX_ROUNDS   = 9,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        bIn,
    input  logic [15:0] switchIn,
    output logic [15:0] redLight,
    output logic [3:0]  score,
    output logic [3:0]  round,
    output logic        gameWait,
    output logic        timerEnable,
    output logic        gameTimeout,
    output logic        endGame,
    output logic        win
);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW,
        WAIT_IN,
        CHECK,
        DONE
    } state_t;

    localparam logic [15:0] SHOW_LOAD   = 16'(SHOW_CYCLES - 1);
    localparam logic [15:0] INPUT_LOAD  = 16'(INPUT_CYCLES - 1);
    localparam logic [3:0]  ROUND_LIMIT = 4'(MAX_ROUNDS);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] pattern_q, pattern_d;
    logic [15:0] count_q, count_d;
    logic        bInPrev_q;
    logic [15:0] redLight_q, redLight_d;
    logic [3:0]  score_q, score_d;
    logic [3:0]  round_q, round_d;
    logic        gameWait_q, gameWait_d;
    logic        timerEnable_q, timerEnable_d;
    logic        gameTimeout_q, gameTimeout_d;
    logic        endGame_q, endGame_d;
    logic        win_q, win_d;

    logic        buttonEdge;
    logic [15:0] lfsrNext;
    logic [3:0]  roundInc;

    // Galois LFSR step with taps 0xB400.
    assign lfsrNext   = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // A button held high into WAIT_IN is not a submission.
    // Only a low-to-high transition counts.
    assign buttonEdge = bIn & ~bInPrev_q;
    assign roundInc   = round_q + 4'd1;

    // Next-state and next-output logic.
    // Every output register is loaded from the value it should have in the
    // state being entered, so the outputs change on the same edge as the state.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        pattern_d     = pattern_q;
        count_d       = count_q;
        score_d       = score_q;
        round_d       = round_q;
        gameTimeout_d = 1'b0;
        win_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = GEN;
                    score_d = 4'd0;
                    round_d = 4'd0;
                end
            end
            GEN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    lfsr_d    = lfsrNext;
                    pattern_d = lfsrNext;
                    count_d   = SHOW_LOAD;
                    state_d   = SHOW;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (count_q == 16'd0) begin
                    state_d = WAIT_IN;
                    count_d = INPUT_LOAD;
                end else begin
                    count_d = count_q - 16'd1;
                end
            end
            WAIT_IN: begin
                // A submission on the expiry cycle takes priority over the timeout.
                if (!enable) begin
                    state_d = IDLE;
                end else if (buttonEdge) begin
                    state_d = CHECK;
                end else if (count_q == 16'd0) begin
                    state_d       = DONE;
                    gameTimeout_d = 1'b1;
                end else begin
                    count_d = count_q - 16'd1;
                end
            end
            CHECK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (switchIn == pattern_q) begin
                    score_d = (score_q == 4'hF) ? 4'hF : score_q + 4'd1;
                    round_d = roundInc;
                    if (roundInc == ROUND_LIMIT) begin
                        state_d = DONE;
                        win_d   = 1'b1;
                    end else begin
                        state_d = GEN;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    win_d = win_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        redLight_d    = (state_d == SHOW) ? pattern_d : 16'h0000;
        gameWait_d    = (state_d == SHOW);
        timerEnable_d = (state_d == WAIT_IN);
        endGame_d     = (state_d == DONE);
    end

    // State and output registers.
    // Reset returns the generator to the seed.
    // A plain abort does not touch the LFSR, so successive games continue the
    // sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_SEED;
            pattern_q     <= 16'h0000;
            count_q       <= 16'h0000;
            bInPrev_q     <= 1'b0;
            redLight_q    <= 16'h0000;
            score_q       <= 4'd0;
            round_q       <= 4'd0;
            gameWait_q    <= 1'b0;
            timerEnable_q <= 1'b0;
            gameTimeout_q <= 1'b0;
            endGame_q     <= 1'b0;
            win_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            pattern_q     <= pattern_d;
            count_q       <= count_d;
            bInPrev_q     <= bIn;
            redLight_q    <= redLight_d;
            score_q       <= score_d;
            round_q       <= round_d;
            gameWait_q    <= gameWait_d;
            timerEnable_q <= timerEnable_d;
            gameTimeout_q <= gameTimeout_d;
            endGame_q     <= endGame_d;
            win_q         <= win_d;
        end
    end

    assign redLight    = redLight_q;
    assign score       = score_q;
    assign round       = round_q;
    assign gameWait    = gameWait_q;
    assign timerEnable = timerEnable_q;
    assign gameTimeout = gameTimeout_q;
    assign endGame     = endGame_q;
    assign win         = win_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
// Self-checking bench for game_sequencer with a short configuration:
// 4 show cycles, 10 entry cycles and 2 rounds to win.
// The expected pattern stream comes from a software LFSR model.
// Expected score, round and outcome come from counting correct guesses.
module tb_game_sequencer;

    localparam int SHOW_N   = 4;
    localparam int INPUT_N  = 10;
    localparam int ROUNDS_N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        bIn;
    logic [15:0] switchIn;
    logic [15:0] redLight;
    logic [3:0]  score;
    logic [3:0]  round;
    logic        gameWait;
    logic        timerEnable;
    logic        gameTimeout;
    logic        endGame;
    logic        win;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [15:0] modelLfsr   = 16'hACE1;

    game_sequencer #(
        .SHOW_CYCLES (SHOW_N),
        .INPUT_CYCLES(INPUT_N),
        .MAX_ROUNDS  (ROUNDS_N),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bIn        (bIn),
        .switchIn   (switchIn),
        .redLight   (redLight),
        .score      (score),
        .round      (round),
        .gameWait   (gameWait),
        .timerEnable(timerEnable),
        .gameTimeout(gameTimeout),
        .endGame    (endGame),
        .win        (win)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Next pattern of the pseudo-random stream, from the Galois step rule.
    task automatic modelNext(output logic [15:0] p);
        modelLfsr = (modelLfsr >> 1) ^ (modelLfsr[0] ? 16'hB400 : 16'h0000);
        p = modelLfsr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave DONE/IDLE and request a new game.
    task automatic startGame();
        enable = 1'b0;
        bIn    = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    // Wait for the display phase and measure it.
    // Returns with the first entry cycle sampled.
    task automatic waitShow(output bit found, output int len, output logic [15:0] shown, output bit steady);
        found  = 1'b0;
        len    = 0;
        shown  = 16'h0000;
        steady = 1'b1;
        for (int i = 0; i < 20 && gameWait !== 1'b1; i++) tick();
        if (gameWait !== 1'b1) return;
        found = 1'b1;
        shown = redLight;
        while (gameWait === 1'b1 && len < 100) begin
            if (redLight !== shown) steady = 1'b0;
            len++;
            tick();
        end
    endtask

    // Idle in the entry phase for d cycles with the button released.
    task automatic holdWaitIn(input int d, output bit timerOk);
        timerOk = 1'b1;
        bIn     = 1'b0;
        repeat (d) begin
            if (timerEnable !== 1'b1) timerOk = 1'b0;
            tick();
        end
    endtask

    // Submit a guess: one-cycle button pulse, then let CHECK resolve.
    task automatic pressGuess(input logic [15:0] guess);
        switchIn = guess;
        bIn      = 1'b1;
        tick();
        bIn = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; bIn = 1'b0; switchIn = 16'h0000;
        tick();
        tick();
        assertCount++;
        if ({redLight, score, round, gameWait, timerEnable, gameTimeout, endGame, win} !== 29'h0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {redLight, score, round, gameWait, timerEnable, gameTimeout, endGame, win});
        end
        rst = 1'b0;
        modelLfsr = 16'hACE1;
        tick();
        assertCount++;
        if ({redLight, gameWait, timerEnable, endGame} !== 19'h0) begin
            failCount++;
            $display("[TB] FAIL idle_outputs: got %h expected 0", {redLight, gameWait, timerEnable, endGame});
        end
    endtask

    task automatic test_win_path();
        logic [15:0] p, shown;
        logic [15:0] specPat [2];
        bit found, steady, ok;
        int len;
        specPat[0] = 16'hE270;
        specPat[1] = 16'h7138;
        startGame();
        for (int r = 0; r < ROUNDS_N; r++) begin
            modelNext(p);
            waitShow(found, len, shown, steady);
            assertCount++;
            if (found !== 1'b1 || steady !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL win_show_seen r%0d: found=%0d steady=%0d expected 1/1", r, found, steady);
            end
            assertCount++;
            if (len !== SHOW_N) begin
                failCount++;
                $display("[TB] FAIL win_show_len r%0d: got %0d expected %0d", r, len, SHOW_N);
            end
            assertCount++;
            if (shown !== p || shown !== specPat[r]) begin
                failCount++;
                $display("[TB] FAIL win_pattern r%0d: got %h expected %h", r, shown, specPat[r]);
            end
            holdWaitIn($urandom_range(0, 8), ok);
            assertCount++;
            if (ok !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL win_timer_en r%0d: got %0d expected 1", r, ok);
            end
            pressGuess(p);
            assertCount++;
            if (score !== 4'(r + 1) || round !== 4'(r + 1)) begin
                failCount++;
                $display("[TB] FAIL win_score r%0d: got score=%0d round=%0d expected %0d", r, score, round, r + 1);
            end
        end
        assertCount++;
        if ({endGame, win, gameTimeout} !== 3'b110) begin
            failCount++;
            $display("[TB] FAIL win_done: got endGame/win/timeout=%b expected 110", {endGame, win, gameTimeout});
        end
        tick();
        assertCount++;
        if ({endGame, win, score} !== {2'b11, 4'd2}) begin
            failCount++;
            $display("[TB] FAIL win_hold: got endGame=%b win=%b score=%0d expected 1 1 2", endGame, win, score);
        end
        enable = 1'b0;
        tick();
        assertCount++;
        if ({endGame, win, score} !== {2'b00, 4'd2}) begin
            failCount++;
            $display("[TB] FAIL win_to_idle: got endGame=%b win=%b score=%0d expected 0 0 2", endGame, win, score);
        end
    endtask

    task automatic test_mismatch();
        logic [15:0] p, shown, flip;
        bit found, steady, ok, sawTimeout;
        int len;
        startGame();
        modelNext(p);
        waitShow(found, len, shown, steady);
        assertCount++;
        if (shown !== p) begin
            failCount++;
            $display("[TB] FAIL mis_pattern: got %h expected %h", shown, p);
        end
        holdWaitIn($urandom_range(0, 8), ok);
        flip = 16'h0001 << $urandom_range(0, 15);
        sawTimeout = 1'b0;
        switchIn = p ^ flip;
        bIn = 1'b1;
        tick();
        sawTimeout |= gameTimeout;
        assertCount++;
        if (timerEnable !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mis_check_state: got timerEnable=%b expected 0", timerEnable);
        end
        bIn = 1'b0;
        tick();
        sawTimeout |= gameTimeout;
        assertCount++;
        if ({endGame, win, score, round} !== {2'b10, 4'd0, 4'd0}) begin
            failCount++;
            $display("[TB] FAIL mis_done: got endGame=%b win=%b score=%0d round=%0d expected 1 0 0 0", endGame, win, score, round);
        end
        repeat (2) begin
            tick();
            sawTimeout |= gameTimeout;
        end
        assertCount++;
        if (sawTimeout !== 1'b0 || endGame !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mis_no_timeout: got timeoutSeen=%b endGame=%b expected 0 1", sawTimeout, endGame);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] p, shown;
        bit found, steady;
        int len, cnt;
        startGame();
        modelNext(p);
        waitShow(found, len, shown, steady);
        assertCount++;
        if (shown !== p) begin
            failCount++;
            $display("[TB] FAIL to_pattern: got %h expected %h", shown, p);
        end
        cnt = 0;
        while (timerEnable === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        assertCount++;
        if (cnt !== INPUT_N) begin
            failCount++;
            $display("[TB] FAIL to_timer_len: got %0d expected %0d", cnt, INPUT_N);
        end
        assertCount++;
        if ({gameTimeout, endGame, win} !== 3'b110) begin
            failCount++;
            $display("[TB] FAIL to_pulse: got timeout/endGame/win=%b expected 110", {gameTimeout, endGame, win});
        end
        tick();
        assertCount++;
        if ({gameTimeout, endGame} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL to_pulse_len: got timeout/endGame=%b expected 01", {gameTimeout, endGame});
        end
    endtask

    task automatic test_edge_rules();
        logic [15:0] p, shown;
        bit found, steady, ok;
        int len, cnt;
        // Button pressed during the display and held into the entry phase.
        startGame();
        modelNext(p);
        for (int i = 0; i < 20 && gameWait !== 1'b1; i++) tick();
        switchIn = p;
        bIn = 1'b1;
        for (int i = 0; i < 20 && gameWait === 1'b1; i++) tick();
        cnt = 0;
        while (timerEnable === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        assertCount++;
        if (cnt !== INPUT_N || gameTimeout !== 1'b1 || score !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL edge_held: got timer=%0d timeout=%b score=%0d expected %0d 1 0", cnt, gameTimeout, score, INPUT_N);
        end
        bIn = 1'b0;
        // Submission on the very cycle the timer expires.
        startGame();
        modelNext(p);
        waitShow(found, len, shown, steady);
        holdWaitIn(INPUT_N - 1, ok);
        switchIn = p;
        bIn = 1'b1;
        tick();
        assertCount++;
        if ({gameTimeout, endGame, timerEnable} !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL edge_expiry_check: got timeout/endGame/timer=%b expected 000", {gameTimeout, endGame, timerEnable});
        end
        bIn = 1'b0;
        tick();
        assertCount++;
        if ({score, round, gameTimeout, endGame} !== {4'd1, 4'd1, 2'b00}) begin
            failCount++;
            $display("[TB] FAIL edge_expiry_score: got score=%0d round=%0d timeout=%b endGame=%b expected 1 1 0 0", score, round, gameTimeout, endGame);
        end
        modelNext(p);
        waitShow(found, len, shown, steady);
        assertCount++;
        if (shown !== p) begin
            failCount++;
            $display("[TB] FAIL edge_round1_pattern: got %h expected %h", shown, p);
        end
        holdWaitIn($urandom_range(0, 8), ok);
        pressGuess(~p);
        assertCount++;
        if ({endGame, win, score} !== {2'b10, 4'd1}) begin
            failCount++;
            $display("[TB] FAIL edge_round1_done: got endGame=%b win=%b score=%0d expected 1 0 1", endGame, win, score);
        end
    endtask

    task automatic test_abort();
        logic [15:0] p;
        startGame();
        modelNext(p);
        for (int i = 0; i < 20 && gameWait !== 1'b1; i++) tick();
        assertCount++;
        if (redLight !== p || gameWait !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL abort_show: got redLight=%h gameWait=%b expected %h 1", redLight, gameWait, p);
        end
        tick();
        enable = 1'b0;
        tick();
        assertCount++;
        if ({redLight, gameWait, endGame, score, round} !== {16'h0, 2'b00, 4'd0, 4'd0}) begin
            failCount++;
            $display("[TB] FAIL abort_idle: got redLight=%h gameWait=%b endGame=%b score=%0d round=%0d expected 0 0 0 0 0", redLight, gameWait, endGame, score, round);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p, shown;
        bit found, steady;
        int len;
        startGame();
        modelNext(p);
        waitShow(found, len, shown, steady);
        tick();
        tick();
        rst = 1'b1;
        tick();
        assertCount++;
        if ({redLight, score, round, gameWait, timerEnable, gameTimeout, endGame, win} !== 29'h0) begin
            failCount++;
            $display("[TB] FAIL rst_mid_outputs: got %h expected 0", {redLight, score, round, gameWait, timerEnable, gameTimeout, endGame, win});
        end
        rst = 1'b0;
        modelLfsr = 16'hACE1;
        modelNext(p);
        waitShow(found, len, shown, steady);
        assertCount++;
        if (shown !== p || shown !== 16'hE270) begin
            failCount++;
            $display("[TB] FAIL rst_mid_reseed: got %h expected %h", shown, 16'hE270);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] p, shown, flip;
        bit found, steady, ok, correct, expDone, expWin;
        int len, expScore;
        for (int g = 0; g < 4; g++) begin
            startGame();
            expScore = 0;
            expDone  = 1'b0;
            for (int r = 0; r < ROUNDS_N && !expDone; r++) begin
                modelNext(p);
                waitShow(found, len, shown, steady);
                assertCount++;
                if (shown !== p) begin
                    failCount++;
                    $display("[TB] FAIL rnd_pattern g%0d r%0d: got %h expected %h", g, r, shown, p);
                end
                correct = ($urandom_range(0, 3) != 0);
                flip = 16'h0001 << $urandom_range(0, 15);
                holdWaitIn($urandom_range(0, 8), ok);
                pressGuess(correct ? p : (p ^ flip));
                if (correct) expScore++;
                expWin  = correct && (expScore == ROUNDS_N);
                expDone = !correct || expWin;
                assertCount++;
                if ({score, round, endGame, win} !== {4'(expScore), 4'(expScore), expDone, expWin}) begin
                    failCount++;
                    $display("[TB] FAIL rnd_result g%0d r%0d: got score=%0d round=%0d endGame=%b win=%b expected %0d %0d %b %b",
                             g, r, score, round, endGame, win, expScore, expScore, expDone, expWin);
                end
            end
        end
        enable = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; bIn = 1'b0; switchIn = 16'h0000;
        test_reset();
        test_win_path();
        test_mismatch();
        test_timeout();
        test_edge_rules();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
